cart_tracker: RTL and testbench
===============================

// Module: cart_tracker
// PURPOSE
//  Customer-cart bookkeeping stage that feeds the list/price display overlay.
//  Accepts one "item added" event at a time (item id + unit price) and updates:
//   - per-item quantity table;
//   - chronological list of distinct items bought;
//   - distinct-item count;
//   - binary running total.
//  Converts the total to 4 BCD digits with a sequential double-dabble, so the
//  display reads stable, already-decomposed digits.
// PARAMETERS
//  NUM_ITEMS  12  number of item ids (valid ids 0..NUM_ITEMS-1)
//  MAX_QTY    7   max quantity per item (fits 3-bit quantity entry)
//  PRICE_W    14  width of unit price and running total (max total 9999)
//  EMPTY_ID   15  filler code for unused shopping_list slots
// PORTS
//  clk            in   1        system clock (pixel-domain clock)
//  rst_n          in   1        asynchronous active-low reset
//  clear          in   1        sync: start new customer, wipes cart
//  add_valid      in   1        add request
//  add_id         in   4        item id to add
//  add_price      in   PRICE_W  unit price of that item, integer units
//  add_ready      out  1        1 only in IDLE (combinational from state)
//  reject         out  1        1-cycle pulse: last request refused
//  reject_code    out  2        1=bad id 2=qty at MAX_QTY 3=total overflow; held until next reject
//  price_valid    out  1        1-cycle pulse: price_disp just refreshed
//  soldItemCount  out  4        number of distinct items in cart (0..12)
//  shopping_list  out  4 x12    [k] = id of k-th distinct item bought, else EMPTY_ID
//  quantitylist   out  3 x12    [id] = quantity of item id
//  price_disp     out  4 x4     BCD total, [0]=thousands .. [3]=units
//  total_price    out  PRICE_W  binary running total
// BEHAVIOUR
//  Reset (async, rst_n=0) and clear (sync, highest priority, any state) give identical state:
//   - shopping_list all EMPTY_ID; quantitylist all 0;
//   - soldItemCount, total_price and every price_disp digit 0;
//   - reject, price_valid and reject_code 0; state IDLE.
//  clear mid-CONVERT aborts the conversion; no price_valid is emitted.
//  accept = add_valid & add_ready & ~clear; no effect unless accept=1.
//  FSM IDLE -> CONVERT -> IDLE; REJECT is a 1-cycle pulse, not a state.
//  IDLE, on accept, checks in order:
//   - add_id>=NUM_ITEMS              -> reject code 1
//   - quantitylist[add_id]==MAX_QTY  -> reject code 2
//   - total_price+add_price>9999     -> reject code 3 (sum computed PRICE_W+1 wide)
//   - On reject: reject=1 on the next cycle; nothing else changes; stay in IDLE.
//  Otherwise, on the accepting edge:
//   - quantitylist[add_id]++ and total_price += add_price;
//   - if the old quantity was 0: shopping_list[soldItemCount]<=add_id and
//     soldItemCount++ (cannot exceed NUM_ITEMS, ids are distinct);
//   - state -> CONVERT and the double-dabble is loaded with the new total.
//  CONVERT lasts exactly PRICE_W (14) cycles, 1 shift per cycle, add-3 applied to
//   any BCD nibble >=5 before each shift. price_disp keeps its old value throughout.
//  On the edge ending the 14th CONVERT cycle: price_disp <= the 4 nibbles, atomically.
//   price_valid=1 for the following cycle. state -> IDLE.
//  Latency: accept edge -> price_disp valid = 14 clocks. Throughput: 1 add per 15 clocks.
//  add_valid held high while add_ready=0 is ignored; it is taken when IDLE returns.
//  Lists and count update at the accept edge, before price_disp follows. Display tolerates this.
//  Zero-price add is legal: quantity still increments and a conversion still runs.
// TESTING
//  1. rst_n low then high: all shopping_list=15, qty=0, count=0, price_disp=0000, add_ready=1.
//  2. add id3 price125: count=1, list[0]=3, qty[3]=1.
//     14 clk later price_disp=0,1,2,5 and price_valid pulses once.
//  3. then add id3 p125, id7 p40: qty[3]=2, list=3,7,15..., count=2, price_disp=0,2,9,0.
//  4. add id5 eight times: 8th gives reject, code2; qty[5] stays 7, total unchanged.
//  5. total 9990, add p20: reject code3. Add id12: reject code1. State unchanged in both.
//  6. clear (and separately rst_n=0) at CONVERT cycle 7: next cycle all cleared, add_ready=1,
//     no price_valid.
//     clear with add_valid same cycle: add not taken.

Source files
------------

// File: rtl/cart_tracker.sv
// Customer-cart bookkeeping: per-item quantities, distinct-item list and running total,
// with a sequential double-dabble that publishes the total as four stable BCD digits.
module cart_tracker #(
    parameter int NUM_ITEMS = 12,
    parameter int MAX_QTY   = 7,
    parameter int PRICE_W   = 14,
    parameter int EMPTY_ID  = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            add_valid,
    input  logic [3:0]                      add_id,
    input  logic [PRICE_W-1:0]              add_price,
    output logic                            add_ready,
    output logic                            reject,
    output logic [1:0]                      reject_code,
    output logic                            price_valid,
    output logic [3:0]                      soldItemCount,
    output logic [NUM_ITEMS-1:0][3:0]       shopping_list,
    output logic [NUM_ITEMS-1:0][2:0]       quantitylist,
    output logic [0:3][3:0]                 price_disp,
    output logic [PRICE_W-1:0]              total_price
);

    localparam int                DD_W     = 16 + PRICE_W;
    localparam logic [3:0]        LP_NUM   = 4'(NUM_ITEMS);
    localparam logic [2:0]        LP_MAX   = 3'(MAX_QTY);
    localparam logic [3:0]        LP_EMPTY = 4'(EMPTY_ID);
    localparam logic [PRICE_W:0]  LP_LIMIT = (PRICE_W+1)'(9999);
    localparam logic [3:0]        LP_LAST  = 4'(PRICE_W - 1);

    typedef enum logic {S_IDLE, S_CONVERT} state_t;

    state_t             r_state;
    logic [DD_W-1:0]    r_dd;
    logic [3:0]         r_cnt;

    logic [PRICE_W:0]   w_sum;
    logic [2:0]         w_qty;
    logic               w_bad_id;
    logic [DD_W-1:0]    w_dd_next;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int d = 0; d < 4; d++) begin
            if (t[PRICE_W + 4*d +: 4] >= 4'd5)
                t[PRICE_W + 4*d +: 4] = t[PRICE_W + 4*d +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

    // Total limit check done one bit wider so a wrapped sum cannot sneak under 9999.
    function automatic logic over_limit(input logic [PRICE_W:0] s);
        return (s > LP_LIMIT);
    endfunction

    assign add_ready = (r_state == S_IDLE);
    assign w_sum     = {1'b0, total_price} + {1'b0, add_price};
    assign w_bad_id  = (add_id >= LP_NUM);
    assign w_qty     = w_bad_id ? 3'd0 : quantitylist[add_id];
    assign w_dd_next = dd_step(r_dd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_dd          <= '0;
            r_cnt         <= '0;
            reject        <= 1'b0;
            reject_code   <= 2'd0;
            price_valid   <= 1'b0;
            soldItemCount <= 4'd0;
            shopping_list <= {NUM_ITEMS{LP_EMPTY}};
            quantitylist  <= '0;
            price_disp    <= '0;
            total_price   <= '0;
        end else if (clear) begin
            // New customer: same state as reset, and any running conversion is dropped.
            r_state       <= S_IDLE;
            r_dd          <= '0;
            r_cnt         <= '0;
            reject        <= 1'b0;
            reject_code   <= 2'd0;
            price_valid   <= 1'b0;
            soldItemCount <= 4'd0;
            shopping_list <= {NUM_ITEMS{LP_EMPTY}};
            quantitylist  <= '0;
            price_disp    <= '0;
            total_price   <= '0;
        end else begin
            reject      <= 1'b0;
            price_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (add_valid) begin
                        if (w_bad_id) begin
                            reject      <= 1'b1;
                            reject_code <= 2'd1;
                        end else if (w_qty == LP_MAX) begin
                            reject      <= 1'b1;
                            reject_code <= 2'd2;
                        end else if (over_limit(w_sum)) begin
                            reject      <= 1'b1;
                            reject_code <= 2'd3;
                        end else begin
                            quantitylist[add_id] <= w_qty + 3'd1;
                            total_price          <= w_sum[PRICE_W-1:0];
                            if (w_qty == 3'd0) begin
                                shopping_list[soldItemCount] <= add_id;
                                soldItemCount                <= soldItemCount + 4'd1;
                            end
                            r_dd    <= {16'd0, w_sum[PRICE_W-1:0]};
                            r_cnt   <= 4'd0;
                            r_state <= S_CONVERT;
                        end
                    end
                end
                S_CONVERT: begin
                    r_dd  <= w_dd_next;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LP_LAST) begin
                        price_disp  <= w_dd_next[DD_W-1 -: 16];
                        price_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_tracker.sv
// Directed bench for cart_tracker: reference cart model plus a queue of expected BCD displays.
module tb_cart_tracker;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              add_valid;
    logic [3:0]        add_id;
    logic [13:0]       add_price;
    logic              add_ready;
    logic              reject;
    logic [1:0]        reject_code;
    logic              price_valid;
    logic [3:0]        soldItemCount;
    logic [11:0][3:0]  shopping_list;
    logic [11:0][2:0]  quantitylist;
    logic [0:3][3:0]   price_disp;
    logic [13:0]       total_price;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];

    logic [2:0]  m_qty[12];
    logic [3:0]  m_list[12];
    int          m_cnt;
    int          m_total;
    int          m_code;
    logic [15:0] m_disp;

    cart_tracker dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .add_valid(add_valid),
        .add_id(add_id), .add_price(add_price), .add_ready(add_ready),
        .reject(reject), .reject_code(reject_code), .price_valid(price_valid),
        .soldItemCount(soldItemCount), .shopping_list(shopping_list),
        .quantitylist(quantitylist), .price_disp(price_disp), .total_price(total_price)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 12; k++) begin
            m_qty[k]  = 3'd0;
            m_list[k] = 4'd15;
        end
        m_cnt   = 0;
        m_total = 0;
        m_code  = 0;
        m_disp  = 16'h0000;
    endtask

    task automatic chk_state();
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("list[%0d]", k), 32'(shopping_list[k]), 32'(m_list[k]));
            chk($sformatf("qty[%0d]", k), 32'(quantitylist[k]), 32'(m_qty[k]));
        end
        chk("count", 32'(soldItemCount), m_cnt);
        chk("total", 32'(total_price), m_total);
        chk("rcode_held", 32'(reject_code), m_code);
        chk("disp_state", 32'(price_disp), 32'(m_disp));
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!add_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", 32'(add_ready), 1);
    endtask

    task automatic do_add(input logic [3:0] id, input logic [13:0] p);
        int code;
        wait_ready();
        code = 0;
        if (id >= 4'd12)              code = 1;
        else if (m_qty[id] == 3'd7)   code = 2;
        else if (m_total + int'(p) > 9999) code = 3;
        add_valid = 1'b1;
        add_id    = id;
        add_price = p;
        @(posedge clk); #1;
        add_valid = 1'b0;
        if (code != 0) begin
            m_code = code;
            chk("reject", 32'(reject), 1);
            chk("rcode", 32'(reject_code), code);
            chk("ready_rej", 32'(add_ready), 1);
            chk_state();
            @(posedge clk); #1;
            chk("reject_pulse", 32'(reject), 0);
        end else begin
            if (m_qty[id] == 3'd0) begin
                m_list[m_cnt] = id;
                m_cnt++;
            end
            m_qty[id] = m_qty[id] + 3'd1;
            m_total   = m_total + int'(p);
            sb_q.push_back(to_bcd(m_total));
            chk("ready_busy", 32'(add_ready), 0);
            chk_state();
            repeat (13) @(posedge clk);
            #1;
            chk("pv_early", 32'(price_valid), 0);
            chk("disp_hold", 32'(price_disp), 32'(m_disp));
            @(posedge clk); #1;
            chk("pv", 32'(price_valid), 1);
            m_disp = to_bcd(m_total);
            @(posedge clk); #1;
            chk("pv_pulse", 32'(price_valid), 0);
            chk("ready_back", 32'(add_ready), 1);
        end
    endtask

    // Scoreboard: every price_valid pulse must match the oldest pending expected display.
    always @(negedge clk) begin
        if (rst_n && price_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pv", 32'(price_valid), 0);
            end else begin
                chk("sb_disp", 32'(price_disp), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; add_valid = 1'b0; add_id = 4'd0; add_price = 14'd0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state();
        chk("ready_rst", 32'(add_ready), 1);
        chk("reject_rst", 32'(reject), 0);
        chk("pv_rst", 32'(price_valid), 0);

        do_add(4'd3, 14'd125);
        chk("disp_0125", 32'(price_disp), 32'h0125);
        do_add(4'd3, 14'd125);
        do_add(4'd7, 14'd40);
        chk("disp_0290", 32'(price_disp), 32'h0290);

        for (int i = 0; i < 8; i++) do_add(4'd5, 14'd10);
        chk("qty5_max", 32'(quantitylist[5]), 7);

        do_add(4'd0, 14'd9630);
        chk("disp_9990", 32'(price_disp), 32'h9990);
        do_add(4'd1, 14'd20);
        do_add(4'd12, 14'd20);
        do_add(4'd5, 14'd20);
        do_add(4'd15, 14'd0);
        do_add(4'd1, 14'd9);
        chk("disp_9999", 32'(price_disp), 32'h9999);
        do_add(4'd2, 14'd0);
        chk("qty2_zero_price", 32'(quantitylist[2]), 1);

        // clear during the 7th conversion cycle
        wait_ready();
        add_valid = 1'b1; add_id = 4'd4; add_price = 14'd50;
        @(posedge clk); #1;
        add_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_reset();
        chk_state();
        chk("ready_clr", 32'(add_ready), 1);
        for (int i = 0; i < 16; i++) begin
            chk("pv_after_clr", 32'(price_valid), 0);
            @(posedge clk); #1;
        end

        do_add(4'd8, 14'd300);
        // asynchronous reset during the 7th conversion cycle
        wait_ready();
        add_valid = 1'b1; add_id = 4'd6; add_price = 14'd77;
        @(posedge clk); #1;
        add_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk_state();
        chk("ready_arst", 32'(add_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("pv_after_rst", 32'(price_valid), 0);
            @(posedge clk); #1;
        end

        // clear beats a simultaneous add request
        add_valid = 1'b1; add_id = 4'd2; add_price = 14'd30; clear = 1'b1;
        @(posedge clk); #1;
        add_valid = 1'b0; clear = 1'b0;
        chk_state();
        chk("ready_clr_add", 32'(add_ready), 1);
        chk("reject_clr_add", 32'(reject), 0);

        do_add(4'd9, 14'd1234);
        chk("disp_1234", 32'(price_disp), 32'h1234);
        do_add(4'd11, 14'd5000);
        chk("list1_id11", 32'(shopping_list[1]), 11);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
